// File: rtl/working_regfile_pkg.sv
// rtl/working_regfile_pkg.sv - shared processor constants for the working register file
package working_regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;

    localparam logic [DEF_DATA_W-1:0] ZERO_DATA = '0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: mux, write forwarding, busy lookup
module regfile_read_port
    import working_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic [DATA_W-1:0]   regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   sel,
    output logic [DATA_W-1:0]   data,
    output logic                busy_out
);

    logic sel_is_r0;
    logic fwd_hit;
    logic rsv_hit;

    // Select stored data, forward in-flight write data, and resolve pending status
    always_comb begin
        sel_is_r0 = (ZERO_R0 != 0) && (sel == '0);
        fwd_hit   = (BYPASS != 0) && wr_en && (wr_addr == sel) && !sel_is_r0;
        rsv_hit   = rsv_en && (rsv_addr == sel);
        data      = regs[sel];
        busy_out  = busy[sel];
        if (sel_is_r0) begin
            data = DATA_W'(ZERO_DATA);
        end else if (fwd_hit) begin
            data = wr_data;
        end
        // A write completing this cycle resolves the hazard unless a new producer claims it too
        if (fwd_hit && !rsv_hit) begin
            busy_out = 1'b0;
        end
    end

endmodule

// File: rtl/working_regfile.sv
// rtl/working_regfile.sv - two-read one-write register file with reservation scoreboard
module working_regfile
    import working_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] sel1,
    input  logic [ADDR_W-1:0] sel2,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              rsv_conflict
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_is_r0;
    logic                rsv_is_r0;

    // Next scoreboard: a write clears its target, a reserve sets it and wins a tie
    always_comb begin
        wr_is_r0  = (ZERO_R0 != 0) && (wr_addr == '0);
        rsv_is_r0 = (ZERO_R0 != 0) && (rsv_addr == '0);
        busy_next = busy;
        if (wr_en && !wr_is_r0) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_en && !rsv_is_r0) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Storage array, written through a clock enable; r0 is read-only when hardwired to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(ZERO_DATA);
            end
        end else if (wr_en && !wr_is_r0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard update and one-cycle flag for reserving an already-pending register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= '0;
            rsv_conflict <= 1'b0;
        end else begin
            busy         <= busy_next;
            rsv_conflict <= rsv_en && busy[rsv_addr];
        end
    end

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_R0  (ZERO_R0)
    ) u_port1 (
        .regs     (regs),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .sel      (sel1),
        .data     (out1),
        .busy_out (busy1)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_R0  (ZERO_R0)
    ) u_port2 (
        .regs     (regs),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .sel      (sel2),
        .data     (out2),
        .busy_out (busy2)
    );

endmodule

// File: tb/tb_working_regfile.sv
// tb/tb_working_regfile.sv - self-checking bench for working_regfile (two configurations)
module tb_working_regfile;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] sel1;
    logic [2:0] sel2;
    logic       rsv_en;
    logic [2:0] rsv_addr;

    logic [7:0] out1_a, out2_a, out1_b, out2_b;
    logic       busy1_a, busy2_a, conf_a;
    logic       busy1_b, busy2_b, conf_b;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 is BYPASS=1/ZERO_R0=0, index 1 is BYPASS=0/ZERO_R0=1
    bit         cfg_byp [2] = '{1'b1, 1'b0};
    bit         cfg_zr  [2] = '{1'b0, 1'b1};
    logic [7:0] m_regs  [2][8];
    bit         m_busy  [2][8];
    bit         m_conf  [2];

    working_regfile dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sel1(sel1), .sel2(sel2), .out1(out1_a), .out2(out2_a),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1_a), .busy2(busy2_a),
        .rsv_conflict(conf_a)
    );

    working_regfile #(.DATA_W(8), .NUM_REGS(8), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sel1(sel1), .sel2(sel2), .out1(out1_b), .out2(out2_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1_b), .busy2(busy2_b),
        .rsv_conflict(conf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] exp_out(input int c, input logic [2:0] sel);
        if (cfg_zr[c] && sel == 3'd0) return 8'h00;
        if (cfg_byp[c] && wr_en && wr_addr == sel) return wr_data;
        return m_regs[c][sel];
    endfunction

    function automatic logic exp_busy(input int c, input logic [2:0] sel);
        if (cfg_byp[c] && wr_en && wr_addr == sel && !(rsv_en && rsv_addr == sel)
            && !(cfg_zr[c] && sel == 3'd0)) return 1'b0;
        return m_busy[c][sel];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    m_regs[c][i] = 8'h00;
                    m_busy[c][i] = 1'b0;
                end
                m_conf[c] = 1'b0;
            end else begin
                m_conf[c] = rsv_en && m_busy[c][rsv_addr];
                if (wr_en && !(cfg_zr[c] && wr_addr == 3'd0)) begin
                    m_regs[c][wr_addr] = wr_data;
                    m_busy[c][wr_addr] = 1'b0;
                end
                if (rsv_en && !(cfg_zr[c] && rsv_addr == 3'd0)) m_busy[c][rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic settle();
        #2;
        chk("a_out1", out1_a, exp_out(0, sel1));
        chk("a_out2", out2_a, exp_out(0, sel2));
        chk("a_busy1", {7'd0, busy1_a}, {7'd0, exp_busy(0, sel1)});
        chk("a_busy2", {7'd0, busy2_a}, {7'd0, exp_busy(0, sel2)});
        chk("a_conflict", {7'd0, conf_a}, {7'd0, m_conf[0]});
        chk("b_out1", out1_b, exp_out(1, sel1));
        chk("b_out2", out2_b, exp_out(1, sel2));
        chk("b_busy1", {7'd0, busy1_b}, {7'd0, exp_busy(1, sel1)});
        chk("b_busy2", {7'd0, busy2_b}, {7'd0, exp_busy(1, sel2)});
        chk("b_conflict", {7'd0, conf_b}, {7'd0, m_conf[1]});
    endtask

    task automatic commit();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset  = 1'b0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_conf[c] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_regs[c][i] = 8'h00;
                m_busy[c][i] = 1'b0;
            end
        end
        reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
        wr_addr = 3'd0; wr_data = 8'h00; rsv_addr = 3'd0; sel1 = 3'd0; sel2 = 3'd0;
        commit();
        commit();

        // Reset state on every address
        idle();
        for (int i = 0; i < 8; i++) begin
            sel1 = 3'(i);
            sel2 = 3'(7 - i);
            settle();
            chk("rst_out1", out1_a, 8'h00);
            chk("rst_busy2", {7'd0, busy2_a}, 8'h00);
            commit();
        end

        // Write then read, then same-cycle forwarding versus stored value
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        settle(); commit();
        idle(); sel1 = 3'd3;
        settle(); chk("r3_read", out1_a, 8'hA5); commit();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; sel2 = 3'd3;
        settle();
        chk("r3_bypass", out2_a, 8'h5A);
        chk("r3_nobypass", out2_b, 8'hA5);
        commit();

        // Reserve, then the producing write resolves busy
        idle(); rsv_en = 1'b1; rsv_addr = 3'd5;
        settle(); commit();
        idle(); sel1 = 3'd5;
        settle(); chk("r5_busy", {7'd0, busy1_a}, 8'h01); commit();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h11;
        settle();
        chk("r5_fwd_busy", {7'd0, busy1_a}, 8'h00);
        chk("r5_fwd_data", out1_a, 8'h11);
        commit();
        idle();
        settle(); chk("r5_after", {7'd0, busy1_a}, 8'h00); chk("r5_data", out1_a, 8'h11); commit();

        // Simultaneous reserve and write, then a conflicting second reserve
        rsv_en = 1'b1; rsv_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h33;
        settle(); commit();
        idle(); sel1 = 3'd2; rsv_en = 1'b1; rsv_addr = 3'd2;
        settle();
        chk("r2_busy", {7'd0, busy1_a}, 8'h01);
        chk("r2_data", out1_a, 8'h33);
        commit();
        idle();
        settle(); chk("r2_conflict", {7'd0, conf_a}, 8'h01); commit();
        settle(); chk("r2_conflict_end", {7'd0, conf_a}, 8'h00); commit();

        // Hardwired r0 on the second instance
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 3'd0; sel1 = 3'd0;
        settle(); commit();
        settle(); commit();
        idle();
        settle();
        chk("r0_out", out1_b, 8'h00);
        chk("r0_busy", {7'd0, busy1_b}, 8'h00);
        chk("r0_conflict", {7'd0, conf_b}, 8'h00);
        commit();

        // Reset abandons data and reservations; a write during reset is lost
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h77; rsv_en = 1'b1; rsv_addr = 3'd1;
        settle(); commit();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99; rsv_en = 1'b1; rsv_addr = 3'd1;
        commit();
        idle(); sel1 = 3'd1;
        settle();
        chk("rst_r1_data", out1_a, 8'h00);
        chk("rst_r1_busy", {7'd0, busy1_a}, 8'h00);
        commit();

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            rsv_en   = $urandom_range(0, 2) == 0;
            wr_addr  = 3'($urandom_range(0, 7));
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            sel1     = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            sel2     = ($urandom_range(0, 4) == 0) ? sel1 : 3'($urandom_range(0, 7));
            if (!reset) settle();
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/working_regfile.md
WORKING_REGFILE -- requirements
Module: working_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of each register in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning the number of registers (a power of two, at least 2).
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_REGS), meaning the register address width.
REQ-004 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 SHALL have parameter ZERO_R0, default 0, meaning register 0 reads as zero and ignores writes when 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-009 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-010 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-011 SHALL have ports sel1 and sel2, input, ADDR_W bits each: read addresses for ports 1 and 2.
REQ-012 SHALL have ports out1 and out2, output, DATA_W bits each: read data for ports 1 and 2.
REQ-013 SHALL have port rsv_en, input, 1 bit: reserve strobe, marking a register pending.
REQ-014 SHALL have port rsv_addr, input, ADDR_W bits: register to reserve.
REQ-015 SHALL have ports busy1 and busy2, output, 1 bit each: pending status of sel1 and sel2.
REQ-016 SHALL have port rsv_conflict, output, 1 bit: registered one-cycle pulse on a reservation of an already-busy register.

Function
REQ-017 SHALL write wr_data into register wr_addr on the rising edge when wr_en=1 and reset=0.
REQ-018 SHALL drive out1/out2 combinationally from the registers addressed by sel1/sel2, with zero-cycle read latency.
REQ-019 With BYPASS=1, SHALL drive wr_data on outN when wr_en=1 and wr_addr==selN in the same cycle; with BYPASS=0, SHALL drive the pre-write stored value.
REQ-020 With ZERO_R0=1, SHALL return 0 on any read of address 0, suppress bypass for address 0, ignore writes to 0, and never set busy[0].
REQ-021 SHALL keep one busy bit per register; rsv_en sets busy[rsv_addr] and wr_en clears busy[wr_addr] on the same edge.
REQ-022 On a simultaneous reserve and write to the same address, SHALL apply set-priority so busy stays 1 (new producer pending) and the data is still written.
REQ-023 SHALL drive busyN combinationally as busy[selN]; with BYPASS=1, SHALL force busyN to 0 when wr_en=1, wr_addr==selN and no same-cycle reserve of selN.
REQ-024 SHALL assert rsv_conflict on the cycle after any rsv_en targeting an address whose busy bit was already 1, for one cycle per offending request.
REQ-025 SHALL accept writes to non-busy registers normally, with no error flag.
REQ-026 SHALL allow sel1==sel2 with identical outputs.

Reset
REQ-027 While reset=1 at a rising edge, SHALL clear all registers to 0, all busy bits to 0 and rsv_conflict to 0, ignoring wr_en and rsv_en that cycle.
REQ-028 After reset, SHALL show out1=out2=0 and busy1=busy2=0 for any selN, in the absence of a same-cycle bypass.
REQ-029 SHALL abandon any reservation in flight when reset is asserted mid-operation; no state survives reset.

Structure
REQ-030 SHALL place the default widths (DATA_W=8, NUM_REGS=8) and a zero-data constant in the shared processor package.
REQ-031 SHALL implement the storage as a clock-enabled register array on clk, with no gated clocks.
REQ-032 SHALL implement the two read ports by instantiating one sub-module, regfile_read_port, twice; it contains the mux, the bypass and the busy lookup.

Verification
REQ-033 Reset then read all addresses -> out1=out2=0x00 and busy1=busy2=0 everywhere.
REQ-034 Write 0xA5 to r3, then next cycle sel1=3 -> out1=0xA5; with wr_en r3=0x5A and sel2=3 in the same cycle -> out2=0x5A (BYPASS=1) or 0xA5 (BYPASS=0).
REQ-035 rsv r5, then sel1=5 -> busy1=1; write r5=0x11 -> busy1 reads 0 in that cycle (bypass) and stays 0 afterwards, out1=0x11.
REQ-036 rsv r2 and write r2=0x33 in the same cycle -> next cycle busy[2]=1 and out=0x33; a second rsv r2 -> rsv_conflict=1 for exactly one cycle.
REQ-037 ZERO_R0=1: write r0=0xFF and rsv r0 -> out1(sel1=0)=0x00, busy1=0, rsv_conflict=0.
REQ-038 Assert reset with r1=0x77 and r1 busy -> next cycle r1=0x00, busy=0; a write issued during reset is lost.
